// File: rtl/mul_add_result_drain.sv
// -----------------------------------------------------------------------------
// mul_add_result_drain
// Downstream stage of the MulAdd accelerator. Captures the result beat stream
// (which cannot be stalled) into a show-ahead FIFO, tags every FRAME_LEN-th
// beat as end-of-frame, and re-presents the beats on a valid/ready interface.
// Beats arriving while the FIFO is full are dropped and flagged sticky.
//
// Optional feature macro: MUL_ADD_RESULT_DRAIN_RELU_EN
//   defined   -> negative payloads (MSB set) are stored as zero
//   undefined -> payloads are stored unmodified
//
// Ports:
//   clk_data          in   sole clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   result_valid_i    in   input beat strobe (no ready)
//   result_payload_i  in   input beat data [DATA_W]
//   out_valid_o       out  output beat available (FIFO not empty)
//   out_ready_i       in   consumer accepts the beat
//   out_payload_o     out  output beat data [DATA_W]
//   out_last_o        out  final beat of a frame
//   level_o           out  FIFO occupancy [$clog2(DEPTH)+1]
//   frame_cnt_o       out  frames fully delivered, wraps [16]
//   overflow_o        out  sticky: an input beat was dropped
// -----------------------------------------------------------------------------
module mul_add_result_drain #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 8
) (
  input  logic                     clk_data,
  input  logic                     rst_n,
  input  logic                     result_valid_i,
  input  logic [DATA_W-1:0]        result_payload_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_payload_o,
  output logic                     out_last_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [15:0]              frame_cnt_o,
  output logic                     overflow_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  // Payload transform applied on the write side.
  function automatic logic [DATA_W-1:0] store_value(input logic [DATA_W-1:0] d);
`ifdef MUL_ADD_RESULT_DRAIN_RELU_EN
    store_value = d[DATA_W-1] ? {DATA_W{1'b0}} : d;
`else
    store_value = d;
`endif
  endfunction

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [DATA_W:0]   mem_r [DEPTH];
  logic [IDX_W-1:0]  idx_r;
  logic [15:0]       frame_cnt_r;
  logic              overflow_r;

  logic [PTR_W-1:0]  level_s;
  logic [1:0]        fifo_state_s;
  logic              full_s;
  logic              empty_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic              beat_last_s;
  logic [DATA_W:0]   head_s;

  // Occupancy and FIFO state derived purely from the pointers.
  always_comb begin
    level_s = wr_ptr_r - rd_ptr_r;
    if (level_s == PTR_W'(0)) begin
      fifo_state_s = ST_EMPTY;
    end else if (level_s == PTR_W'(DEPTH)) begin
      fifo_state_s = ST_FULL;
    end else begin
      fifo_state_s = ST_PARTIAL;
    end
  end

  // Decode state into the full/empty qualifiers used by the handshakes.
  always_comb begin
    full_s  = 1'b0;
    empty_s = 1'b0;
    case (fifo_state_s)
      ST_EMPTY:   empty_s = 1'b1;
      ST_PARTIAL: begin
        full_s  = 1'b0;
        empty_s = 1'b0;
      end
      ST_FULL:    full_s  = 1'b1;
      default: begin
        full_s  = 1'b1;
        empty_s = 1'b1;
      end
    endcase
  end

  // Handshake qualifiers; full is judged at cycle start, so a same-cycle
  // read never makes room for the write.
  always_comb begin
    wr_en_s     = result_valid_i & ~full_s;
    rd_en_s     = ~empty_s & out_ready_i;
    beat_last_s = (idx_r == IDX_W'(FRAME_LEN - 1));
    head_s      = mem_r[rd_ptr_r[AW-1:0]];
  end

  // FIFO storage and write pointer.
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(DATA_W+1){1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {beat_last_s, store_value(result_payload_i)};
      wr_ptr_r                <= wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer and delivered-frame counter.
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r    <= {PTR_W{1'b0}};
      frame_cnt_r <= 16'd0;
    end else if (rd_en_s) begin
      rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      if (head_s[DATA_W]) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
    end else begin
      rd_ptr_r    <= rd_ptr_r;
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Beat index advances on every upstream beat, dropped or not, so framing
  // stays aligned with the producer.
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (result_valid_i) begin
      if (beat_last_s) begin
        idx_r <= {IDX_W{1'b0}};
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  // Sticky overflow: set by any beat arriving while full.
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (result_valid_i && full_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Outputs are taken straight from state registers (show-ahead head entry).
  assign out_valid_o   = ~empty_s;
  assign out_payload_o = head_s[DATA_W-1:0];
  assign out_last_o    = head_s[DATA_W];
  assign level_o       = level_s;
  assign frame_cnt_o   = frame_cnt_r;
  assign overflow_o    = overflow_r;

endmodule

// File: tb/tb_mul_add_result_drain.sv
module tb_mul_add_result_drain;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int FL    = 8;

  logic          clk_data = 1'b0;
  logic          rst_n;
  logic          result_valid_i;
  logic [DW-1:0] result_payload_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_payload_o;
  logic          out_last_o;
  logic [4:0]    level_o;
  logic [15:0]   frame_cnt_o;
  logic          overflow_o;

  always #5 clk_data = ~clk_data;

  mul_add_result_drain #(.DATA_W(DW), .DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
    .clk_data(clk_data), .rst_n(rst_n),
    .result_valid_i(result_valid_i), .result_payload_i(result_payload_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_payload_o(out_payload_o), .out_last_o(out_last_o),
    .level_o(level_o), .frame_cnt_o(frame_cnt_o), .overflow_o(overflow_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] relu_m(input logic [31:0] d);
`ifdef MUL_ADD_RESULT_DRAIN_RELU_EN
    return ($signed(d) < 0) ? 32'd0 : d;
`else
    return d;
`endif
  endfunction

  // Behavioural model: a queue of {last, payload}, a beat index, counters.
  logic [32:0] mq[$];
  logic [32:0] dut_log[$];
  int          m_idx = 0;
  bit          m_ovf = 1'b0;
  int          m_fc  = 0;

  initial begin
    bit          m_full;
    bit          m_rd;
    bit          m_lst;
    logic [32:0] m_head;
    forever begin
      @(posedge clk_data or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_idx = 0;
        m_ovf = 1'b0;
        m_fc  = 0;
      end else begin
        m_full = (mq.size() == DEPTH);
        m_rd   = (mq.size() > 0) && out_ready_i;
        if (out_valid_o && out_ready_i) dut_log.push_back({out_last_o, out_payload_o});
        if (m_rd) begin
          m_head = mq.pop_front();
          if (m_head[32]) m_fc = (m_fc + 1) % 65536;
        end
        if (result_valid_i) begin
          m_lst = (m_idx == FL - 1);
          m_idx = m_lst ? 0 : m_idx + 1;
          if (m_full) m_ovf = 1'b1;
          else mq.push_back({m_lst, relu_m(result_payload_i)});
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_data) begin
    if (cmp_en && rst_n) begin
      chk("valid", {63'd0, out_valid_o}, {63'd0, (mq.size() > 0)});
      chk("level", {59'd0, level_o}, 64'(mq.size()));
      chk("frame_cnt", {48'd0, frame_cnt_o}, 64'(m_fc));
      chk("overflow", {63'd0, overflow_o}, {63'd0, m_ovf});
      if (mq.size() > 0) begin
        chk("payload", {32'd0, out_payload_o}, {32'd0, mq[0][31:0]});
        chk("last", {63'd0, out_last_o}, {63'd0, mq[0][32]});
      end
    end
  end

  task automatic send(input logic [31:0] d);
    @(negedge clk_data);
    result_valid_i   = 1'b1;
    result_payload_i = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_data);
      result_valid_i = 1'b0;
    end
  endtask

  task automatic chk_beat(input string nm, input int i, input logic [31:0] p, input logic l);
    if (i < dut_log.size()) begin
      chk($sformatf("%s[%0d]", nm, i), {31'd0, dut_log[i]}, {31'd0, l, p});
    end else begin
      n_checks++;
      $display("FAIL %s[%0d]: got no beat expected %0h last %0d", nm, i, p, l);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " valid"}, {63'd0, out_valid_o}, 64'd0);
    chk({nm, " payload"}, {32'd0, out_payload_o}, 64'd0);
    chk({nm, " last"}, {63'd0, out_last_o}, 64'd0);
    chk({nm, " level"}, {59'd0, level_o}, 64'd0);
    chk({nm, " frame_cnt"}, {48'd0, frame_cnt_o}, 64'd0);
    chk({nm, " overflow"}, {63'd0, overflow_o}, 64'd0);
  endtask

  initial begin
    rst_n            = 1'b0;
    result_valid_i   = 1'b0;
    result_payload_i = 32'd0;
    out_ready_i      = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk_data);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Single frame with consumer always ready.
    out_ready_i = 1'b1;
    dut_log.delete();
    for (int i = 0; i < 8; i++) send(32'(10 + i));
    idle(3);
    chk("frame log size", 64'(dut_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk_beat("frame", i, 32'(10 + i), (i == 7));
    chk("frame fc", {48'd0, frame_cnt_o}, 64'd1);
    chk("frame level", {59'd0, level_o}, 64'd0);

    // Overflow: fill with 16, then two dropped beats.
    out_ready_i = 1'b0;
    dut_log.delete();
    for (int i = 0; i < 16; i++) send(32'(i));
    send(32'd100);
    send(32'd101);
    idle(1);
    chk("ovf level", {59'd0, level_o}, 64'd16);
    chk("ovf flag", {63'd0, overflow_o}, 64'd1);
    out_ready_i = 1'b1;
    idle(18);
    chk("ovf log size", 64'(dut_log.size()), 64'd16);
    for (int i = 0; i < 16; i++) chk_beat("ovf", i, 32'(i), (i == 7) || (i == 15));
    chk("ovf fc", {48'd0, frame_cnt_o}, 64'd3);
    // Index continues at 2, so the 6th following beat closes the frame.
    dut_log.delete();
    for (int i = 0; i < 6; i++) send(32'(200 + i));
    idle(3);
    chk("idx log size", 64'(dut_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk_beat("idx", i, 32'(200 + i), (i == 5));
    chk("idx fc", {48'd0, frame_cnt_o}, 64'd4);

    // Backpressure: ready toggles every cycle.
    dut_log.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_data);
      out_ready_i      = ~out_ready_i;
      result_valid_i   = 1'b1;
      result_payload_i = 32'(20 + i);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_data);
      out_ready_i    = ~out_ready_i;
      result_valid_i = 1'b0;
    end
    out_ready_i = 1'b1;
    idle(2);
    chk("bp log size", 64'(dut_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk_beat("bp", i, 32'(20 + i), (i == 7));
    chk("bp fc", {48'd0, frame_cnt_o}, 64'd5);

    // RELU behaviour.
    dut_log.delete();
    send(32'hFFFF_FFF6);
    send(32'd5);
    idle(3);
`ifdef MUL_ADD_RESULT_DRAIN_RELU_EN
    chk_beat("relu", 0, 32'd0, 1'b0);
`else
    chk_beat("relu", 0, 32'hFFFF_FFF6, 1'b0);
`endif
    chk_beat("relu", 1, 32'd5, 1'b0);

    // Reset mid-frame.
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send(32'(30 + i));
    idle(1);
    chk("mid level before rst", {59'd0, level_o}, 64'd5);
    @(posedge clk_data);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid reset");
    @(negedge clk_data);
    rst_n       = 1'b1;
    out_ready_i = 1'b1;
    dut_log.delete();
    for (int i = 0; i < 8; i++) send(32'(40 + i));
    idle(3);
    chk("post rst log size", 64'(dut_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk_beat("post rst", i, 32'(40 + i), (i == 7));
    chk("post rst fc", {48'd0, frame_cnt_o}, 64'd1);
    chk("post rst level", {59'd0, level_o}, 64'd0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
